// File: rtl/interp_filter.sv
// interp_filter: expands each PID word into 2^ism linear DAC steps.
// Build option: define INTERP_PREEMPT_EN to let new words preempt a ramp.
module interp_filter #(
  parameter int W_DATA   = 18,
  parameter int W_ISM    = 3,
  parameter int ISM_INIT = 0
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic signed [W_DATA-1:0] data_in,
  input  logic                     data_valid_in,
  input  logic                     step_in,
  input  logic [W_ISM-1:0]         ism_in,
  input  logic                     activate_in,
  input  logic                     update_en_in,
  input  logic                     update_in,
  output logic signed [W_DATA-1:0] data_out,
  output logic                     data_valid_out,
  output logic                     busy_out,
  output logic                     overrun_out
);

  localparam int MAX_ISM = 2**W_ISM - 1;
  localparam int W_ACC   = W_DATA + 1 + MAX_ISM;

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_LOAD, S_RAMP
  } state_t;

  state_t state_q, state_d;

  logic signed [W_ACC-1:0]  acc_q, acc_d;
  logic signed [W_ACC-1:0]  acc_nxt, acc_sh, dout_ext;
  logic signed [W_DATA:0]   delta_q, delta_d;
  logic [MAX_ISM-1:0]       cnt_q, cnt_d, last_cnt;
  logic [W_ISM-1:0]         ism_cur_q, ism_cur_d;
  logic [W_ISM-1:0]         ism_ramp_q, ism_ramp_d;
  logic signed [W_DATA-1:0] tgt_q, tgt_d;
  logic signed [W_DATA-1:0] pend_q, pend_d;
  logic signed [W_DATA-1:0] dout_q, dout_d;
  logic                     pvld_q, pvld_d;
  logic                     dv_q, dv_d;
  logic                     ovr_q, ovr_d;
  logic                     last;
  logic                     unused_acc;

  assign dout_ext =
    {{(W_ACC-W_DATA){dout_q[W_DATA-1]}}, dout_q};
  assign acc_nxt =
    acc_q + {{MAX_ISM{delta_q[W_DATA]}}, delta_q};
  assign acc_sh     = acc_nxt >>> ism_ramp_q;
  assign unused_acc = ^acc_sh[W_ACC-1:W_DATA];
  assign last_cnt   = ~({MAX_ISM{1'b1}} << ism_ramp_q);
  assign last       = (cnt_q == last_cnt);

  assign data_out       = dout_q;
  assign data_valid_out = dv_q;
  assign busy_out       = (state_q == S_LOAD) ||
                          (state_q == S_RAMP);
  assign overrun_out    = ovr_q;

  // Next-state, ramp datapath and pending-word bookkeeping
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    delta_d    = delta_q;
    cnt_d      = cnt_q;
    ism_ramp_d = ism_ramp_q;
    tgt_d      = tgt_q;
    pend_d     = pend_q;
    pvld_d     = pvld_q;
    dout_d     = dout_q;
    dv_d       = 1'b0;
    ovr_d      = ovr_q;
    ism_cur_d  = ism_cur_q;
    if (update_in && update_en_in) ism_cur_d = ism_in;
    if (!activate_in) begin
      state_d = S_IDLE;
      pvld_d  = 1'b0;
      ovr_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_WAIT;
        S_WAIT: begin
          if (data_valid_in) begin
            tgt_d   = data_in;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          ism_ramp_d = ism_cur_q;
          acc_d      = dout_ext <<< ism_cur_q;
          delta_d    = {tgt_q[W_DATA-1], tgt_q} -
                       {dout_q[W_DATA-1], dout_q};
          cnt_d      = '0;
          state_d    = S_RAMP;
`ifdef INTERP_PREEMPT_EN
          // A newer word retargets before any step was taken.
          if (data_valid_in) begin
            tgt_d   = data_in;
            state_d = S_LOAD;
          end
`else
          if (data_valid_in) begin
            pend_d = data_in;
            pvld_d = 1'b1;
            if (pvld_q) ovr_d = 1'b1;
          end
`endif
        end
        S_RAMP: begin
          if (step_in) begin
            acc_d  = acc_nxt;
            dout_d = acc_sh[W_DATA-1:0];
            dv_d   = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
`ifdef INTERP_PREEMPT_EN
          if (data_valid_in) begin
            tgt_d   = data_in;
            state_d = S_LOAD;
          end else if (step_in && last) begin
            state_d = S_WAIT;
          end
`else
          if (data_valid_in) begin
            pend_d = data_in;
            pvld_d = 1'b1;
            if (pvld_q) ovr_d = 1'b1;
          end
          if (step_in && last) begin
            if (data_valid_in) begin
              tgt_d   = data_in;
              pvld_d  = 1'b0;
              state_d = S_LOAD;
            end else if (pvld_q) begin
              tgt_d   = pend_q;
              pvld_d  = 1'b0;
              state_d = S_LOAD;
            end else begin
              state_d = S_WAIT;
            end
          end
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      delta_q    <= '0;
      cnt_q      <= '0;
      ism_cur_q  <= W_ISM'(ISM_INIT);
      ism_ramp_q <= W_ISM'(ISM_INIT);
      tgt_q      <= '0;
      pend_q     <= '0;
      pvld_q     <= 1'b0;
      dout_q     <= '0;
      dv_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      delta_q    <= delta_d;
      cnt_q      <= cnt_d;
      ism_cur_q  <= ism_cur_d;
      ism_ramp_q <= ism_ramp_d;
      tgt_q      <= tgt_d;
      pend_q     <= pend_d;
      pvld_q     <= pvld_d;
      dout_q     <= dout_d;
      dv_q       <= dv_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: doc/interp_filter.md
Name: interp_filter

Overview:
Output-side counterpart of the input oversample filter. It takes one PID output word per controller cycle and expands it into 2^ism evenly spaced DAC updates, one per DAC-cycle tick. Each ramp runs linearly from the currently held output to the new target and lands exactly on the target. It sits between the PID core output and the DAC/DDS instruction path; parameters come from the frontpanel controller.

Parameters:
W_DATA, 18, width of signed input/output data
W_ISM, 3, width of interpolation-mode signal; MAX_ISM = 2**W_ISM - 1 (log2 of the maximum step count)
ISM_INIT, 0, interpolation mode loaded on reset

Ports:
clk_in  input  1  system clock; the only clock
reset_in  input  1  synchronous, active-high system reset
data_in  input  W_DATA  signed target word from PID core
data_valid_in  input  1  one-cycle strobe qualifying data_in
step_in  input  1  one-cycle DAC-cycle tick; advances the ramp by one step
ism_in  input  W_ISM  frontpanel log2 step count
activate_in  input  1  channel activation (1 = active)
update_en_in  input  1  sensitizes the module to update_in
update_in  input  1  pulse latching ism_in into ism_cur when update_en_in=1
data_out  output  W_DATA  signed interpolated output, registered
data_valid_out  output  1  one-cycle pulse: data_out has a new step value
busy_out  output  1  high in LOAD or RAMP
overrun_out  output  1  sticky: a pending target was overwritten

Behaviour:
- Reset (reset_in=1): state=IDLE; acc=0; data_out=0; data_valid_out=0; busy_out=0; overrun_out=0; pending cleared; ism_cur=ISM_INIT. Reset mid-ramp aborts the ramp immediately.
- ism_cur update: when update_in & update_en_in, ism_cur <= ism_in. update_en_in without update_in has no effect.
- ism_cur is snapshotted into ism_ramp at LOAD. A change during a ramp takes effect at the next ramp only.
- Datapath:
  - acc is signed, W_DATA+1+MAX_ISM bits; delta is signed, W_DATA+1 bits.
  - In LOAD: acc <= sext(data_out) << ism_ramp; delta <= target - data_out; step_cnt <= 0.
  - Each step: acc <= acc + sext(delta).
  - data_out = acc >>> ism_ramp (arithmetic shift, rounds toward -inf), registered.
  - After 2^ism_ramp steps, acc == target << ism_ramp exactly. No saturation is required.
- States:
  - IDLE: output held at its last value. If activate_in=1 -> WAIT.
  - WAIT: no ramp in progress. On data_valid_in, capture target -> LOAD.
  - LOAD: one cycle, performs the datapath load -> RAMP. A step_in arriving in LOAD is dropped.
  - RAMP: on step_in, acc steps and step_cnt++. The step where step_cnt == 2^ism_ramp - 1 is the last one; then go to LOAD if pending is valid (pending -> target, pending cleared), else WAIT.
- Latency: step_in at cycle t -> new data_out and data_valid_out=1 at t+1. step_in in IDLE or WAIT produces no output and no pulse.
- data_valid_in in WAIT coinciding with step_in: data is captured and the step is ignored.
- data_valid_in during LOAD/RAMP: stored in a 1-deep pending register.
  - If pending is already valid, it is overwritten by the newest word and overrun_out is set.
  - data_valid_in coinciding with the last step: the word goes to pending and is consumed by the immediate LOAD.
- ism=0: a single step; data_out = target at t+1 after the first step_in.
- activate_in=0 in any state: -> IDLE next cycle. Pending and overrun_out are cleared; data_out and ism_cur are retained (no DAC jump).

Optional Feature:
INTERP_PREEMPT_EN
- Defined: data_valid_in during RAMP preempts the current ramp. Next cycle goes to LOAD from the current data_out toward the new word, and step_cnt restarts. The pending register is unused and overrun_out stays 0.
- Undefined: queued behaviour as specified above.

Test Plan:
- Reset, activate, ism=2 via update; data_in=100, then 4 step_in ticks -> data_out 25,50,75,100, each with a 1-cycle data_valid_out; busy_out drops after the 4th step.
- From 100, ism=2, data_in=-3 -> data_out 74,48,22,-3 (floor rounding, exact endpoint).
- ism=0, data_in=-131072 (min value) -> one step_in yields -131072; further step_in ticks give no valid pulse.
- During a 4-step ramp to 100, send 200 then 300 -> overrun_out=1, next ramp targets 300. With INTERP_PREEMPT_EN: sending 200 after step 2 (data_out=50) ramps 50 -> 200 via 87,125,162,200; overrun_out=0.
- Change ism 2 -> 3 mid-ramp -> current ramp still 4 steps; the next ramp uses 8 steps.
- Deassert activate_in mid-ramp -> IDLE, data_out frozen, no valid pulses; reassert and send a word -> ramp starts from the frozen value. Assert reset_in mid-ramp -> all outputs 0 the next cycle.
